// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic-array result path: default array
// geometry, the drain state encoding and a packed-row column accessor.
package tpu_pkg;

    localparam int ARRAY_SIZE_DEF = 2;
    localparam int ACC_W_DEF      = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } drain_state_e;

    // Column c of a default-geometry packed row (column c at [c*ACC_W +: ACC_W]).
    function automatic logic [ACC_W_DEF-1:0] row_col(
        input logic [ARRAY_SIZE_DEF*ACC_W_DEF-1:0] row,
        input int                                  c
    );
        return row[c*ACC_W_DEF +: ACC_W_DEF];
    endfunction

endpackage

// File: rtl/result_drain_if.sv
// Row output handshake from the drain to the memory-store path.
interface result_drain_if #(
    parameter int ARRAY_SIZE = 2,
    parameter int ACC_W      = 16
);
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_last;
    logic [ARRAY_SIZE*ACC_W-1:0] out_row;

    modport master (output out_valid, output out_row, output out_last, input out_ready);
    modport slave  (input out_valid, input out_row, input out_last, output out_ready);
endinterface

// File: rtl/drain_col_fifo.sv
// Single-column synchronous FIFO. Flush has priority over push/pop; a push
// into a full FIFO only lands when the same cycle also pops.
module drain_col_fifo #(
    parameter int ACC_W      = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [ACC_W-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [ACC_W-1:0] head
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [ACC_W-1:0] mem_q [FIFO_DEPTH];
    logic [ACC_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (cnt_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Next pointers, occupancy and storage contents.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage and pointer registers; storage clears on reset so the head reads 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/result_drain.sv
// Realigns the skewed per-column partial sums leaving the systolic array into
// whole rows and hands them to the store path over valid/ready.
// Optional build macro RESULT_DRAIN_RELU_EN clamps negative output elements
// to zero at the output mux; FIFO contents and timing are unaffected.
//
// state   | meaning
// IDLE    | waiting for tile_start, array output ignored
// COLLECT | pushing columns, emitting rows when every column has data
// DONE    | one-cycle tile_done pulse, then back to IDLE
module result_drain
    import tpu_pkg::*;
#(
    parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tile_start,
    input  logic [ARRAY_SIZE-1:0]       sa_valid,
    input  logic [ARRAY_SIZE*ACC_W-1:0] sa_data,
    result_drain_if.master              out_if,
    output logic                        tile_done,
    output logic                        busy,
    output logic                        overflow
);
    localparam int CNT_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

    drain_state_e              state_q, state_d;
    logic [CNT_W-1:0]          row_cnt_q, row_cnt_d;
    logic                      overflow_q, overflow_d;
    logic [ARRAY_SIZE-1:0]     col_full, col_empty, col_push;
    logic [ACC_W-1:0]          col_head [ARRAY_SIZE];
    logic [ARRAY_SIZE*ACC_W-1:0] row_c;
    logic [ACC_W-1:0]          elem;
    logic                      handshake, flush, row_last;

    // tile_start arriving during the DONE pulse is not an arming event.
    assign flush     = tile_start & (state_q != DONE);
    assign col_push  = sa_valid & {ARRAY_SIZE{state_q == COLLECT}};
    assign handshake = out_if.out_valid & out_if.out_ready;
    assign row_last  = (row_cnt_q == CNT_W'(ARRAY_SIZE - 1));

    for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_col
        drain_col_fifo #(.ACC_W(ACC_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (col_push[c]),
            .pop   (handshake),
            .din   (sa_data[c*ACC_W +: ACC_W]),
            .full  (col_full[c]),
            .empty (col_empty[c]),
            .head  (col_head[c])
        );
    end

    // Assemble the output row from the FIFO heads, optionally clamping negatives.
    always_comb begin
        row_c = '0;
        elem  = '0;
        for (int c = 0; c < ARRAY_SIZE; c++) begin
            elem = col_head[c];
`ifdef RESULT_DRAIN_RELU_EN
            if (elem[ACC_W-1]) elem = '0;
`endif
            row_c[c*ACC_W +: ACC_W] = elem;
        end
    end

    assign out_if.out_row   = row_c;
    assign out_if.out_valid = (state_q == COLLECT) && (col_empty == '0);
    assign out_if.out_last  = out_if.out_valid && row_last;
    assign tile_done        = (state_q == DONE);
    assign busy             = (state_q == COLLECT);
    assign overflow         = overflow_q;

    // Next state, row count and sticky overflow.
    always_comb begin
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        overflow_d = overflow_q | (|(col_push & col_full & ~{ARRAY_SIZE{handshake}}));
        case (state_q)
            IDLE: begin
                if (tile_start) begin
                    state_d    = COLLECT;
                    row_cnt_d  = '0;
                    overflow_d = 1'b0;
                end
            end
            COLLECT: begin
                if (tile_start) begin
                    row_cnt_d  = '0;
                    overflow_d = 1'b0;
                end else if (handshake) begin
                    if (row_last) begin
                        state_d   = DONE;
                        row_cnt_d = '0;
                    end else begin
                        row_cnt_d = row_cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            row_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            overflow_q <= overflow_d;
        end
    end
endmodule
